// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  multicycle_ctrl_pkg
//  State encodings, opcodes and select codes shared by the multi-cycle control.
//  Revision: 1.0
// ============================================================================
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_HALT     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam int WAIT_CNT_W = 8;

    // States that hold an outstanding memory access and are watched by the timer.
    function automatic logic is_wait_state(input state_t st);
        return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  multicycle_ctrl_if
//  Control bundle between the multi-cycle control FSM and the datapath.
//  Revision: 1.0
// ============================================================================
interface multicycle_ctrl_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ALU_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_fault;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ALU_op,
               pc_source, illegal_op, mem_fault
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ALU_op,
               pc_source, illegal_op, mem_fault
    );

endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  mem_wait_timer
//  Counts consecutive memory wait cycles; expired flags the cycle that hits limit.
//  Revision: 1.0
// ============================================================================
module mem_wait_timer
    import multicycle_ctrl_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  clear,
    input  wire logic                  enable,
    input  wire logic [WAIT_CNT_W-1:0] limit,
    output logic                       expired
);

    logic [WAIT_CNT_W-1:0] r_count;

    // Expires on the wait cycle that would make the count equal to limit.
    assign expired = enable && (({1'b0, r_count} + 9'd1) >= {1'b0, limit});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  multicycle_ctrl
//  Main control FSM of the multi-cycle MIPS datapath with memory wait watchdog.
//  Revision: 1.0
// ============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    multicycle_ctrl_if.master bus
);

    localparam logic [WAIT_CNT_W-1:0] C_LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES);

    state_t r_state;
    logic   r_is_store;
    logic   w_timer_en;
    logic   w_expired;

    // Any cycle that is not a stalled access resets the count, including exits.
    assign w_timer_en = is_wait_state(r_state) && !bus.mem_ready;

    mem_wait_timer u_mem_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!w_timer_en),
        .enable  (w_timer_en),
        .limit   (C_LIMIT),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RESET;
            r_is_store <= 1'b0;
        end else begin
            case (r_state)
                ST_RESET:    r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (bus.mem_ready)  r_state <= ST_DECODE;
                    else if (w_expired) r_state <= ST_HALT;
                end
                ST_DECODE: begin
                    case (bus.opcode)
                        OP_LW: begin
                            r_is_store <= 1'b0;
                            r_state    <= ST_MEM_ADDR;
                        end
                        OP_SW: begin
                            r_is_store <= 1'b1;
                            r_state    <= ST_MEM_ADDR;
                        end
                        OP_RTYPE: r_state <= ST_R_EXEC;
                        OP_BEQ:   r_state <= ST_BRANCH;
                        OP_J:     r_state <= ST_JUMP;
                        default:  r_state <= ST_FETCH;
                    endcase
                end
                ST_MEM_ADDR: r_state <= r_is_store ? ST_MEM_WR : ST_MEM_RD;
                ST_MEM_RD: begin
                    if (bus.mem_ready)  r_state <= ST_MEM_WB;
                    else if (w_expired) r_state <= ST_HALT;
                end
                ST_MEM_WB:   r_state <= ST_FETCH;
                ST_MEM_WR: begin
                    if (bus.mem_ready)  r_state <= ST_FETCH;
                    else if (w_expired) r_state <= ST_HALT;
                end
                ST_R_EXEC:   r_state <= ST_R_WB;
                ST_R_WB:     r_state <= ST_FETCH;
                ST_BRANCH:   r_state <= ST_FETCH;
                ST_JUMP:     r_state <= ST_FETCH;
                ST_HALT:     r_state <= ST_HALT;
                default:     r_state <= ST_RESET;
            endcase
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = ALUSRCB_B;
        bus.ALU_op        = ALUOP_ADD;
        bus.pc_source     = PCSRC_ALU;
        bus.illegal_op    = 1'b0;
        bus.mem_fault     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = ALUSRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            ST_DECODE: begin
                bus.alu_src_b  = ALUSRCB_IMM_SH2;
                bus.illegal_op = !((bus.opcode == OP_LW) || (bus.opcode == OP_SW) ||
                                   (bus.opcode == OP_RTYPE) || (bus.opcode == OP_BEQ) ||
                                   (bus.opcode == OP_J));
            end
            ST_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ALUSRCB_IMM;
            end
            ST_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            ST_R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.ALU_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.ALU_op        = ALUOP_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCSRC_JUMP;
            end
            ST_HALT:  bus.mem_fault = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_multicycle_ctrl
//  Directed self-checking bench for multicycle_ctrl (watchdog limit set to 4).
//  Revision: 1.0
// ============================================================================
module tb_multicycle_ctrl;

    // Vector layout: pw pwc iod mr mw irw m2r rdst rw asa asb[2] aop[2] pcs[2] ill flt
    localparam logic [17:0] C_ZERO     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_FETCH_W  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] C_FETCH_R  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] C_DECODE   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] C_DEC_ILL  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
    localparam logic [17:0] C_MEM_ADDR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] C_MEM_RD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_MEM_WB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_0;
    localparam logic [17:0] C_MEM_WR   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_R_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] C_R_WB     = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_0;
    localparam logic [17:0] C_BRANCH   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_0;
    localparam logic [17:0] C_JUMP     = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_0;
    localparam logic [17:0] C_HALT     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

    localparam logic [5:0] C_LW  = 6'b100011;
    localparam logic [5:0] C_SW  = 6'b101011;
    localparam logic [5:0] C_R   = 6'b000000;
    localparam logic [5:0] C_BEQ = 6'b000100;
    localparam logic [5:0] C_J   = 6'b000010;
    localparam logic [5:0] C_BAD = 6'b111111;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] ctl_vec();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.ALU_op, bus.pc_source, bus.illegal_op, bus.mem_fault};
    endfunction

    task automatic check(input string tag, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    // One controller cycle: drive inputs after the falling edge, then check outputs.
    task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                       input logic [17:0] exp);
        @(negedge clk);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        #1;
        check(tag, ctl_vec(), exp);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.opcode    = C_R;
        bus.mem_ready = 1'b1;

        cyc("reset_held", C_R, 1'b1, C_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset_state", ctl_vec(), C_ZERO);

        // lw with a zero-wait memory; opcode changed after DECODE must be ignored
        cyc("lw_fetch",  C_R,  1'b1, C_FETCH_R);
        cyc("lw_decode", C_LW, 1'b1, C_DECODE);
        cyc("lw_addr",   C_SW, 1'b1, C_MEM_ADDR);
        cyc("lw_rd",     C_SW, 1'b1, C_MEM_RD);
        cyc("lw_wb",     C_SW, 1'b1, C_MEM_WB);

        cyc("r_fetch",  C_R, 1'b1, C_FETCH_R);
        cyc("r_decode", C_R, 1'b1, C_DECODE);
        cyc("r_exec",   C_R, 1'b1, C_R_EXEC);
        cyc("r_wb",     C_R, 1'b1, C_R_WB);

        cyc("beq_fetch",  C_R,   1'b1, C_FETCH_R);
        cyc("beq_decode", C_BEQ, 1'b1, C_DECODE);
        cyc("beq_branch", C_BEQ, 1'b1, C_BRANCH);

        cyc("j_fetch",  C_R, 1'b1, C_FETCH_R);
        cyc("j_decode", C_J, 1'b1, C_DECODE);
        cyc("j_jump",   C_J, 1'b1, C_JUMP);

        // sw with three stalled write cycles, then a fetch that also stalls three
        cyc("sw_fetch",  C_R,  1'b1, C_FETCH_R);
        cyc("sw_decode", C_SW, 1'b1, C_DECODE);
        cyc("sw_addr",   C_LW, 1'b1, C_MEM_ADDR);
        for (int i = 0; i < 3; i++) cyc("sw_wr_wait", C_R, 1'b0, C_MEM_WR);
        cyc("sw_wr_done", C_R, 1'b1, C_MEM_WR);
        for (int i = 0; i < 3; i++) cyc("fetch_wait3", C_R, 1'b0, C_FETCH_W);
        cyc("fetch_rdy4", C_R, 1'b1, C_FETCH_R);
        cyc("ill_decode", C_BAD, 1'b1, C_DEC_ILL);
        cyc("ill_refetch", C_R, 1'b1, C_FETCH_R);
        cyc("j2_decode", C_J, 1'b1, C_DECODE);
        cyc("j2_jump",   C_J, 1'b1, C_JUMP);

        // Watchdog: four stalled fetch cycles reach the limit of 4
        for (int i = 0; i < 4; i++) cyc("to_fetch_wait", C_R, 1'b0, C_FETCH_W);
        cyc("to_halt",     C_R, 1'b0, C_HALT);
        cyc("to_halt_abs", C_R, 1'b1, C_HALT);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("to_reset_clear", ctl_vec(), C_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("to_reset_state", ctl_vec(), C_ZERO);

        // Asynchronous reset in the middle of a stalled load
        cyc("ar_fetch",  C_R,  1'b1, C_FETCH_R);
        cyc("ar_decode", C_LW, 1'b1, C_DECODE);
        cyc("ar_addr",   C_LW, 1'b1, C_MEM_ADDR);
        cyc("ar_rd",     C_LW, 1'b0, C_MEM_RD);
        #2 rst_n = 1'b0;
        #1 check("ar_async_zero", ctl_vec(), C_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ar_reset_state", ctl_vec(), C_ZERO);
        cyc("ar_fetch_after", C_R, 1'b1, C_FETCH_R);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
